// File: rtl/xctcmsg_pkg.sv
// Shared XCTCMSG types: send requests, network and loopback payloads, writeback records.
package xctcmsg_pkg;

    localparam int unsigned ADDRESS_WIDTH  = 8;
    localparam int unsigned MESSAGE_WIDTH  = 32;
    localparam int unsigned REGISTER_WIDTH = 5;
    localparam int unsigned GL_INDEX_WIDTH = 4;
    localparam int unsigned TAG_WIDTH      = 4;

    typedef logic [ADDRESS_WIDTH-1:0]  address_t;
    typedef logic [MESSAGE_WIDTH-1:0]  message_t;
    typedef logic [REGISTER_WIDTH-1:0] reg_index_t;

    typedef struct packed {
        logic [GL_INDEX_WIDTH-1:0] gl_index;
        logic [TAG_WIDTH-1:0]      tag;
    } passthrough_t;

    typedef struct packed {
        message_t     message;
        address_t     destination;
        reg_index_t   register;
        passthrough_t passthrough;
    } send_queue_data_t;

    typedef struct packed {
        message_t message;
        address_t destination;
    } interface_transmit_data_t;

    typedef struct packed {
        message_t message;
        address_t source;
    } interface_receive_data_t;

    typedef struct packed {
        message_t     value;
        reg_index_t   register;
        passthrough_t passthrough;
    } writeback_arbiter_data_t;

`ifdef XCTCMSG_SARGANTANA
    typedef struct packed {
        logic [GL_INDEX_WIDTH-1:0] payload;
    } commit_safety_request_t;
`else
    typedef struct packed {
        logic reserved;
    } commit_safety_request_t;
`endif

    localparam message_t SEND_OK_VALUE = '0;

    // A message addressed to this core goes to the loopback path instead of the network.
    function automatic logic is_local(input address_t destination, input address_t local_address);
        return destination == local_address;
    endfunction

endpackage

// File: rtl/outbox_fifo.sv
// Synchronous FIFO with flush; head is shown combinationally from storage.
module outbox_fifo #(
    parameter type         T    = logic,
    parameter int unsigned SIZE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head_c,
    output logic o_full_c,
    output logic o_empty_c
);

    localparam int unsigned PTR_W = $clog2(SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 r_mem [SIZE];
    logic [PTR_W-1:0] r_head_ptr;
    logic [PTR_W-1:0] r_tail_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = r_count == CNT_W'(SIZE);
    assign o_empty_c = r_count == '0;
    assign o_head_c  = r_mem[r_head_ptr];
    assign w_push    = i_push & ~o_full_c;
    assign w_pop     = i_pop & ~o_empty_c;

    // Pointers wrap naturally since SIZE is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else if (i_flush) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) r_tail_ptr <= r_tail_ptr + PTR_W'(1);
            if (w_pop)  r_head_ptr <= r_head_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_tail_ptr] <= i_data;
    end

endmodule

// File: rtl/outbox.sv
// Transmit buffer: queues committed sends, routes each to network or loopback, reports completion.
module outbox
    import xctcmsg_pkg::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  address_t                 local_address,
    input  logic                     send_queue_outbox_valid,
    output logic                     outbox_send_queue_ready,
    input  send_queue_data_t         send_queue_outbox_data,
    output logic                     outbox_interface_valid,
    input  logic                     interface_outbox_ready,
    output interface_transmit_data_t outbox_interface_data,
    output logic                     outbox_loopback_valid,
    input  logic                     loopback_outbox_ready,
    output interface_receive_data_t  outbox_loopback_data,
    output logic                     outbox_writeback_arbiter_valid,
    input  logic                     writeback_arbiter_outbox_acknowledge,
    output writeback_arbiter_data_t  outbox_writeback_arbiter_data,
    output commit_safety_request_t   outbox_csu_request,
    input  logic                     csu_outbox_grant
);

    send_queue_data_t        w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_local;
    logic                    w_dispatch_enable;
    logic                    r_wb_valid;
    writeback_arbiter_data_t r_wb_data;

    assign outbox_send_queue_ready = csu_outbox_grant & ~w_full;
    assign w_push                  = send_queue_outbox_valid & outbox_send_queue_ready;

    outbox_fifo #(
        .T    (send_queue_data_t),
        .SIZE (SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush),
        .i_push    (w_push),
        .i_data    (send_queue_outbox_data),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // Dispatch only when the completion slot is free or being drained this cycle.
    always_comb begin
        w_local                = 1'b0;
        w_dispatch_enable      = 1'b0;
        outbox_loopback_valid  = 1'b0;
        outbox_interface_valid = 1'b0;
        w_pop                  = 1'b0;

        w_local                = is_local(w_head.destination, local_address);
        w_dispatch_enable      = ~w_empty & (~r_wb_valid | writeback_arbiter_outbox_acknowledge);
        outbox_loopback_valid  = w_dispatch_enable & w_local;
        outbox_interface_valid = w_dispatch_enable & ~w_local;
        w_pop                  = (outbox_loopback_valid & loopback_outbox_ready)
                               | (outbox_interface_valid & interface_outbox_ready);
    end

    assign outbox_interface_data.message     = w_head.message;
    assign outbox_interface_data.destination = w_head.destination;
    assign outbox_loopback_data.message      = w_head.message;
    assign outbox_loopback_data.source       = local_address;

    // Completion record: a pop loads it, a lone ack retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
        end else if (flush) begin
            r_wb_valid <= 1'b0;
        end else if (w_pop) begin
            r_wb_valid            <= 1'b1;
            r_wb_data.value       <= SEND_OK_VALUE;
            r_wb_data.register    <= w_head.register;
            r_wb_data.passthrough <= w_head.passthrough;
        end else if (writeback_arbiter_outbox_acknowledge) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign outbox_writeback_arbiter_valid = r_wb_valid;
    assign outbox_writeback_arbiter_data  = r_wb_data;

`ifdef XCTCMSG_SARGANTANA
    assign outbox_csu_request.payload = send_queue_outbox_data.passthrough.gl_index;
`else
    assign outbox_csu_request = '0;
`endif

endmodule

// File: tb/tb_outbox.sv
// Bench for outbox: directed vector table, async-reset sequence, randomized run against a queue model.
module tb_outbox;
    import xctcmsg_pkg::*;

    localparam int unsigned SIZE = 4;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    address_t                 local_address;
    logic                     sq_valid;
    logic                     sq_ready;
    send_queue_data_t         sq_data;
    logic                     if_valid;
    logic                     if_ready;
    interface_transmit_data_t if_data;
    logic                     lb_valid;
    logic                     lb_ready;
    interface_receive_data_t  lb_data;
    logic                     wb_valid;
    logic                     wb_ack;
    writeback_arbiter_data_t  wb_data;
    commit_safety_request_t   csu_req;
    logic                     grant;

    int n_total = 0;
    int n_pass  = 0;

    outbox #(.SIZE(SIZE)) dut (
        .clk                                  (clk),
        .rst_n                                (rst_n),
        .flush                                (flush),
        .local_address                        (local_address),
        .send_queue_outbox_valid              (sq_valid),
        .outbox_send_queue_ready              (sq_ready),
        .send_queue_outbox_data               (sq_data),
        .outbox_interface_valid               (if_valid),
        .interface_outbox_ready               (if_ready),
        .outbox_interface_data                (if_data),
        .outbox_loopback_valid                (lb_valid),
        .loopback_outbox_ready                (lb_ready),
        .outbox_loopback_data                 (lb_data),
        .outbox_writeback_arbiter_valid       (wb_valid),
        .writeback_arbiter_outbox_acknowledge (wb_ack),
        .outbox_writeback_arbiter_data        (wb_data),
        .outbox_csu_request                   (csu_req),
        .csu_outbox_grant                     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic       fl;
        logic       sv;
        address_t   dst;
        message_t   msg;
        reg_index_t rg;
        logic       gr;
        logic       ifr;
        logic       lbr;
        logic       ack;
        logic       e_rdy;
        logic       e_ifv;
        logic       e_lbv;
        logic       e_wbv;
        message_t   e_msg;
        reg_index_t e_reg;
    } vec_t;

    function automatic vec_t mk(input int fl, input int sv, input int dst, input int msg, input int rg,
                                input int gr, input int ifr, input int lbr, input int ack,
                                input int rdy, input int ifv, input int lbv, input int wbv,
                                input int emsg, input int ereg);
        vec_t v;
        v.fl = 1'(fl);  v.sv = 1'(sv);  v.dst = 8'(dst);  v.msg = 32'(msg);  v.rg = 5'(rg);
        v.gr = 1'(gr);  v.ifr = 1'(ifr); v.lbr = 1'(lbr); v.ack = 1'(ack);
        v.e_rdy = 1'(rdy); v.e_ifv = 1'(ifv); v.e_lbv = 1'(lbv); v.e_wbv = 1'(wbv);
        v.e_msg = 32'(emsg); v.e_reg = 5'(ereg);
        return v;
    endfunction

    vec_t vecs[$];

    // Reference model state for the randomized run.
    send_queue_data_t        m_q[$];
    logic                    m_wbv;
    writeback_arbiter_data_t m_wb;

    initial begin
        rst_n = 1'b0; flush = 1'b0; local_address = 8'd2;
        sq_valid = 1'b0; sq_data = '0; if_ready = 1'b0; lb_ready = 1'b0; wb_ack = 1'b0; grant = 1'b1;

        // fl sv dst msg rg gr ifr lbr ack | rdy ifv lbv wbv emsg ereg
        vecs.push_back(mk(0,1,5,'hAB,7, 1,1,1,0, 1,0,0,0, 0,0));   // remote push
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,0, 1,1,0,0, 'hAB,0));
        vecs.push_back(mk(0,1,2,'h11,3, 1,1,1,0, 1,0,0,1, 0,7));    // completion for reg 7, local push
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,0, 1,0,0,1, 0,7));    // held by pending completion
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 1,0,1,1, 'h11,7)); // ack frees dispatch same cycle
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 1,0,0,1, 0,3));
        vecs.push_back(mk(0,1,5,'h22,1, 0,1,1,0, 0,0,0,0, 0,0));    // no grant, no push
        vecs.push_back(mk(0,1,5,'h30,1, 1,0,1,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,1,5,'h31,2, 1,0,1,0, 1,1,0,0, 'h30,0));
        vecs.push_back(mk(0,1,5,'h32,3, 1,0,1,0, 1,1,0,0, 'h30,0));
        vecs.push_back(mk(0,1,5,'h33,4, 1,0,1,0, 1,1,0,0, 'h30,0));
        vecs.push_back(mk(0,1,5,'h34,5, 1,0,1,0, 0,1,0,0, 'h30,0)); // full
        vecs.push_back(mk(0,0,0,0,0,    1,0,1,0, 0,1,0,0, 'h30,0));
        vecs.push_back(mk(0,1,5,'h34,5, 1,1,1,0, 0,1,0,0, 'h30,0)); // full refuses even while popping
        vecs.push_back(mk(0,1,5,'h34,5, 1,1,1,0, 1,0,0,1, 0,1));    // slot freed
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,0, 0,0,0,1, 0,1));
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 0,1,0,1, 'h31,1)); // back-to-back across wrap
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 1,1,0,1, 'h32,2));
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 1,1,0,1, 'h33,3));
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 1,1,0,1, 'h34,4));
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 1,0,0,1, 0,5));
        vecs.push_back(mk(0,1,5,'h40,6, 1,0,1,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,1,5,'h41,7, 1,0,1,0, 1,1,0,0, 'h40,0));
        vecs.push_back(mk(0,1,5,'h42,8, 1,0,1,0, 1,1,0,0, 'h40,0));
        vecs.push_back(mk(0,1,5,'h43,9, 1,1,1,0, 1,1,0,0, 'h40,0)); // push+pop, count stays 3
        vecs.push_back(mk(1,1,5,'h99,1, 1,1,1,0, 1,0,0,1, 0,6));    // flush, push dropped
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,1,2,'h55,9, 1,1,1,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,0, 1,0,1,0, 'h55,0));
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,1, 1,0,0,1, 0,9));
        vecs.push_back(mk(0,0,0,0,0,    1,1,1,0, 1,0,0,0, 0,0));

        // Reset state.
        #12;
        chk("reset_ready", 64'(sq_ready), 64'(1));
        chk("reset_ifv", 64'(if_valid), 64'(0));
        chk("reset_lbv", 64'(lb_valid), 64'(0));
        chk("reset_wbv", 64'(wb_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            flush = vecs[i].fl; sq_valid = vecs[i].sv; grant = vecs[i].gr;
            sq_data = '0;
            sq_data.destination = vecs[i].dst; sq_data.message = vecs[i].msg; sq_data.register = vecs[i].rg;
            if_ready = vecs[i].ifr; lb_ready = vecs[i].lbr; wb_ack = vecs[i].ack;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(sq_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("v%0d_ifv", i), 64'(if_valid), 64'(vecs[i].e_ifv));
            chk($sformatf("v%0d_lbv", i), 64'(lb_valid), 64'(vecs[i].e_lbv));
            chk($sformatf("v%0d_wbv", i), 64'(wb_valid), 64'(vecs[i].e_wbv));
            if (vecs[i].e_ifv) begin
                chk($sformatf("v%0d_if_msg", i), 64'(if_data.message), 64'(vecs[i].e_msg));
                chk($sformatf("v%0d_if_dst", i), 64'(if_data.destination), 64'(5));
            end
            if (vecs[i].e_lbv) begin
                chk($sformatf("v%0d_lb_msg", i), 64'(lb_data.message), 64'(vecs[i].e_msg));
                chk($sformatf("v%0d_lb_src", i), 64'(lb_data.source), 64'(2));
            end
            if (vecs[i].e_wbv) begin
                chk($sformatf("v%0d_wb_reg", i), 64'(wb_data.register), 64'(vecs[i].e_reg));
                chk($sformatf("v%0d_wb_val", i), 64'(wb_data.value), 64'(0));
            end
        end

        // Asynchronous reset in the middle of a cycle with work queued.
        @(negedge clk);
        flush = 1'b0; sq_valid = 1'b1; grant = 1'b1; if_ready = 1'b0; wb_ack = 1'b0;
        sq_data = '0; sq_data.destination = 8'd5; sq_data.message = 32'h77;
        @(negedge clk);
        sq_valid = 1'b0;
        #1;
        chk("pre_rst_ifv", 64'(if_valid), 64'(1));
        grant = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ifv", 64'(if_valid), 64'(0));
        chk("async_rst_ready", 64'(sq_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; grant = 1'b1; if_ready = 1'b1;
        #1;
        chk("post_rst_ifv", 64'(if_valid), 64'(0));
        chk("post_rst_ready", 64'(sq_ready), 64'(1));

        // Randomized run against a queue model.
        m_q.delete(); m_wbv = 1'b0; m_wb = '0;
        for (int c = 0; c < 2000; c++) begin
            logic exp_rdy, en, loc, exp_ifv, exp_lbv, pop;
            @(negedge clk);
            flush    = ($urandom_range(0, 99) < 2);
            sq_valid = 1'($urandom_range(0, 1));
            grant    = ($urandom_range(0, 9) < 8);
            if_ready = 1'($urandom_range(0, 1));
            lb_ready = 1'($urandom_range(0, 1));
            wb_ack   = ($urandom_range(0, 9) < 7);
            sq_data.message     = $urandom;
            sq_data.destination = 8'($urandom_range(1, 3));
            sq_data.register    = 5'($urandom);
            sq_data.passthrough = 8'($urandom);
            #1;
            exp_rdy = grant && (m_q.size() < SIZE);
            en      = (m_q.size() != 0) && (!m_wbv || wb_ack);
            loc     = en && (m_q[0].destination == local_address);
            exp_ifv = en && !loc;
            exp_lbv = en && loc;
            chk("rnd_ready", 64'(sq_ready), 64'(exp_rdy));
            chk("rnd_ifv", 64'(if_valid), 64'(exp_ifv));
            chk("rnd_lbv", 64'(lb_valid), 64'(exp_lbv));
            chk("rnd_wbv", 64'(wb_valid), 64'(m_wbv));
            if (exp_ifv) chk("rnd_if_data", 64'(if_data), 64'({m_q[0].message, m_q[0].destination}));
            if (exp_lbv) chk("rnd_lb_data", 64'(lb_data), 64'({m_q[0].message, local_address}));
            if (m_wbv)   chk("rnd_wb_data", 64'(wb_data), 64'(m_wb));
            pop = (exp_ifv && if_ready) || (exp_lbv && lb_ready);
            if (flush) begin
                m_q.delete();
                m_wbv = 1'b0;
            end else begin
                if (pop) begin
                    m_wbv = 1'b1;
                    m_wb.value = 32'd0;
                    m_wb.register = m_q[0].register;
                    m_wb.passthrough = m_q[0].passthrough;
                    void'(m_q.pop_front());
                end else if (wb_ack) begin
                    m_wbv = 1'b0;
                end
                if (sq_valid && exp_rdy) m_q.push_back(sq_data);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
